// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the M-extension divide control unit and its iterative divider.
package div_ctrl_pkg;

   localparam int unsigned DivXlen = 32;

   typedef enum logic [1:0] {
      DIV_OP_DIV  = 2'b00,
      DIV_OP_DIVU = 2'b01,
      DIV_OP_REM  = 2'b10,
      DIV_OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      DIV_ST_IDLE = 2'b00,
      DIV_ST_BUSY = 2'b01,
      DIV_ST_DONE = 2'b10
   } div_state_e;

   localparam logic [DivXlen-1:0] ZeroWord = {DivXlen{1'b0}};
   localparam logic [DivXlen-1:0] AllOnes  = {DivXlen{1'b1}};
   localparam logic [DivXlen-1:0] MinInt   = {1'b1, {(DivXlen-1){1'b0}}};

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_special_case.sv
// Combinational detection of divide-by-zero and signed overflow with the architected result.
module div_special_case
   import div_ctrl_pkg::*;
(
   input  div_op_e              op,
   input  logic [DivXlen-1:0]   dividend,
   input  logic [DivXlen-1:0]   divisor,
   output logic                 is_special,
   output logic [DivXlen-1:0]   result
);

   logic is_signed_s;
   logic is_rem_s;

   assign is_signed_s = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
   assign is_rem_s    = (op == DIV_OP_REM) || (op == DIV_OP_REMU);

   // Zero divisor takes priority; overflow only exists for signed ops.
   always_comb begin
      is_special = 1'b0;
      result     = ZeroWord;
      if (divisor == ZeroWord) begin
         is_special = 1'b1;
         result     = is_rem_s ? dividend : AllOnes;
      end else if (is_signed_s && (dividend == MinInt) && (divisor == AllOnes)) begin
         is_special = 1'b1;
         result     = is_rem_s ? ZeroWord : MinInt;
      end else begin
         is_special = 1'b0;
         result     = ZeroWord;
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Execute-stage sequencer for DIV/DIVU/REM/REMU: launches the iterative divider,
// stalls the pipeline while it runs and issues a single write-back.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int unsigned XLEN           = DivXlen,
   parameter int unsigned TIMEOUT_CYCLES = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid_i,
   input  logic [1:0]        op_i,
   input  logic [XLEN-1:0]   dividend_i,
   input  logic [XLEN-1:0]   divisor_i,
   input  logic [4:0]        rd_addr_i,
   input  logic              flush_i,
   output logic              div_start_o,
   output logic [XLEN-1:0]   div_dividend_o,
   output logic [XLEN-1:0]   div_divisor_o,
   output logic              div_signed_o,
   input  logic              div_ready_i,
   input  logic [2*XLEN-1:0] div_result_i,
   output logic              hold_o,
   output logic              wb_en_o,
   output logic [4:0]        wb_addr_o,
   output logic [XLEN-1:0]   wb_data_o,
   output logic              timeout_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   div_state_e          state_r, state_nxt_s;
   logic [1:0]          op_r;
   logic [4:0]          rd_r;
   logic [XLEN-1:0]     dividend_r, divisor_r;
   logic [CNT_W-1:0]    cnt_r;
   logic                div_start_r, div_signed_r;
   logic                wb_en_r, timeout_r;
   logic [4:0]          wb_addr_r;
   logic [XLEN-1:0]     wb_data_r;

   logic                accept_s, hold_s, timeout_nxt_s, signed_nxt_s;
   logic [4:0]          wb_addr_nxt_s;
   logic [XLEN-1:0]     wb_data_nxt_s;
   logic                special_s;
   logic [XLEN-1:0]     special_result_s;

   div_special_case u_special (
      .op         (div_op_e'(op_i)),
      .dividend   (dividend_i),
      .divisor    (divisor_i),
      .is_special (special_s),
      .result     (special_result_s)
   );

   // Next-state, stall request and write-back payload selection.
   always_comb begin
      state_nxt_s   = state_r;
      accept_s      = 1'b0;
      hold_s        = 1'b0;
      timeout_nxt_s = 1'b0;
      signed_nxt_s  = ~op_r[0];
      wb_addr_nxt_s = rd_r;
      wb_data_nxt_s = ZeroWord;
      case (state_r)
         DIV_ST_IDLE: begin
            signed_nxt_s  = ~op_i[0];
            wb_addr_nxt_s = rd_addr_i;
            wb_data_nxt_s = special_result_s;
            if (op_valid_i && !flush_i) begin
               accept_s    = 1'b1;
               hold_s      = 1'b1;
               state_nxt_s = special_s ? DIV_ST_DONE : DIV_ST_BUSY;
            end else begin
               state_nxt_s = DIV_ST_IDLE;
            end
         end
         DIV_ST_BUSY: begin
            if (flush_i) begin
               state_nxt_s = DIV_ST_IDLE;
            end else if (div_ready_i == DivResultReady) begin
               hold_s        = 1'b1;
               state_nxt_s   = DIV_ST_DONE;
               wb_data_nxt_s = op_r[1] ? div_result_i[2*XLEN-1:XLEN] : div_result_i[XLEN-1:0];
            end else if (cnt_r == CNT_LAST) begin
               hold_s        = 1'b1;
               timeout_nxt_s = 1'b1;
               state_nxt_s   = DIV_ST_DONE;
            end else begin
               hold_s      = 1'b1;
               state_nxt_s = DIV_ST_BUSY;
            end
         end
         DIV_ST_DONE: begin
            state_nxt_s = DIV_ST_IDLE;
         end
         default: begin
            state_nxt_s = DIV_ST_IDLE;
         end
      endcase
   end

   // State, operand latches, timeout counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= DIV_ST_IDLE;
         op_r         <= 2'b00;
         rd_r         <= 5'd0;
         dividend_r   <= ZeroWord;
         divisor_r    <= ZeroWord;
         cnt_r        <= {CNT_W{1'b0}};
         div_start_r  <= DivStop;
         div_signed_r <= 1'b0;
         wb_en_r      <= 1'b0;
         wb_addr_r    <= 5'd0;
         wb_data_r    <= ZeroWord;
         timeout_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            op_r       <= op_i;
            rd_r       <= rd_addr_i;
            dividend_r <= dividend_i;
            divisor_r  <= divisor_i;
         end
         cnt_r        <= ((state_r == DIV_ST_BUSY) && (state_nxt_s == DIV_ST_BUSY)) ?
                         cnt_r + CNT_W'(1) : {CNT_W{1'b0}};
         div_start_r  <= (state_nxt_s == DIV_ST_BUSY) ? DivStart : DivStop;
         div_signed_r <= (state_nxt_s == DIV_ST_BUSY) ? signed_nxt_s : 1'b0;
         wb_en_r      <= (state_nxt_s == DIV_ST_DONE);
         wb_addr_r    <= (state_nxt_s == DIV_ST_DONE) ? wb_addr_nxt_s : 5'd0;
         wb_data_r    <= (state_nxt_s == DIV_ST_DONE) ? wb_data_nxt_s : ZeroWord;
         timeout_r    <= timeout_nxt_s;
      end
   end

   assign hold_o         = hold_s;
   assign div_start_o    = div_start_r;
   assign div_signed_o   = div_signed_r;
   assign div_dividend_o = dividend_r;
   assign div_divisor_o  = divisor_r;
   assign wb_en_o        = wb_en_r;
   assign wb_addr_o      = wb_addr_r;
   assign wb_data_o      = wb_data_r;
   assign timeout_o      = timeout_r;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl; the bench plays the role of the iterative divider.
module tb_div_ctrl;

   logic        clk;
   logic        rst;
   logic        op_valid_i;
   logic [1:0]  op_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic [4:0]  rd_addr_i;
   logic        flush_i;
   logic        div_start_o;
   logic [31:0] div_dividend_o;
   logic [31:0] div_divisor_o;
   logic        div_signed_o;
   logic        div_ready_i;
   logic [63:0] div_result_i;
   logic        hold_o;
   logic        wb_en_o;
   logic [4:0]  wb_addr_o;
   logic [31:0] wb_data_o;
   logic        timeout_o;

   int check_cnt;
   int error_cnt;

   div_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(40)) dut (
      .clk            (clk),
      .rst            (rst),
      .op_valid_i     (op_valid_i),
      .op_i           (op_i),
      .dividend_i     (dividend_i),
      .divisor_i      (divisor_i),
      .rd_addr_i      (rd_addr_i),
      .flush_i        (flush_i),
      .div_start_o    (div_start_o),
      .div_dividend_o (div_dividend_o),
      .div_divisor_o  (div_divisor_o),
      .div_signed_o   (div_signed_o),
      .div_ready_i    (div_ready_i),
      .div_result_i   (div_result_i),
      .hold_o         (hold_o),
      .wb_en_o        (wb_en_o),
      .wb_addr_o      (wb_addr_o),
      .wb_data_o      (wb_data_o),
      .timeout_o      (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      check_cnt++;
      if (got !== exp) begin
         error_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".start"},   64'(div_start_o),  64'd0);
      check({tag, ".hold"},    64'(hold_o),       64'd0);
      check({tag, ".wb_en"},   64'(wb_en_o),      64'd0);
      check({tag, ".timeout"}, 64'(timeout_o),    64'd0);
      check({tag, ".signed"},  64'(div_signed_o), 64'd0);
   endtask

   // lat==0 means a locally resolved special case; otherwise ready is returned on BUSY cycle lat.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int lat,
                        input logic [63:0] res, input logic [31:0] exp_wb, input logic exp_signed);
      op_valid_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
      #1;
      check({tag, ".hold_accept"}, 64'(hold_o), 64'd1);
      step();
      op_valid_i = 1'b0;
      dividend_i = 32'h1234_5678; divisor_i = 32'h0000_0000;
      for (int k = 1; k <= lat; k++) begin
         if (k == lat) begin
            div_ready_i = 1'b1; div_result_i = res;
         end
         #1;
         check({tag, ".busy_start"}, 64'(div_start_o), 64'd1);
         check({tag, ".busy_hold"}, 64'(hold_o), 64'd1);
         check({tag, ".busy_signed"}, 64'(div_signed_o), 64'(exp_signed));
         if (k == 1) begin
            check({tag, ".dividend_o"}, 64'(div_dividend_o), 64'(a));
            check({tag, ".divisor_o"}, 64'(div_divisor_o), 64'(b));
         end
         step();
      end
      div_ready_i = 1'b0; div_result_i = 64'd0;
      #1;
      check({tag, ".wb_en"}, 64'(wb_en_o), 64'd1);
      check({tag, ".wb_addr"}, 64'(wb_addr_o), 64'(rd));
      check({tag, ".wb_data"}, 64'(wb_data_o), 64'(exp_wb));
      check({tag, ".done_hold"}, 64'(hold_o), 64'd0);
      check({tag, ".done_start"}, 64'(div_start_o), 64'd0);
      step();
      check({tag, ".wb_en_after"}, 64'(wb_en_o), 64'd0);
   endtask

   initial begin
      check_cnt = 0; error_cnt = 0;
      rst = 1'b1; op_valid_i = 1'b0; op_i = 2'b00; dividend_i = 32'd0; divisor_i = 32'd0;
      rd_addr_i = 5'd0; flush_i = 1'b0; div_ready_i = 1'b0; div_result_i = 64'd0;
      step(); step();
      check_idle_outputs("reset");
      check("reset.wb_data", 64'(wb_data_o), 64'd0);
      check("reset.dividend_o", 64'(div_dividend_o), 64'd0);
      rst = 1'b0;
      step();

      // DIV -20/3 -> q=-6, r=-2, ready after 33 BUSY cycles
      do_op("div_neg", 2'b00, 32'hFFFF_FFEC, 32'd3, 5'd5, 33,
            {32'hFFFF_FFFE, 32'hFFFF_FFFA}, 32'hFFFF_FFFA, 1'b1);
      // REMU 0xFFFFFFFF/16 -> q=0x0FFFFFFF, r=0xF
      do_op("remu", 2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 5'd7, 5,
            {32'h0000_000F, 32'h0FFF_FFFF}, 32'h0000_000F, 1'b0);
      do_op("divu_by0", 2'b01, 32'd7, 32'd0, 5'd9, 0, 64'd0, 32'hFFFF_FFFF, 1'b0);
      do_op("rem_by0", 2'b10, 32'd7, 32'd0, 5'd0, 0, 64'd0, 32'd7, 1'b0);
      do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 64'd0, 32'h8000_0000, 1'b0);
      do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 64'd0, 32'd0, 1'b0);
      // Unsigned with the overflow operands is an ordinary division: q=0, r=0x80000000
      do_op("divu_big", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 3,
            {32'h8000_0000, 32'h0000_0000}, 32'h0000_0000, 1'b0);

      // Ready outside BUSY is ignored; flush masks op_valid in IDLE
      div_ready_i = 1'b1; div_result_i = 64'hDEAD_BEEF_DEAD_BEEF;
      step();
      div_ready_i = 1'b0;
      check("idle_ready.wb_en", 64'(wb_en_o), 64'd0);
      op_valid_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; dividend_i = 32'd5; divisor_i = 32'd0;
      #1;
      check("flush_idle.hold", 64'(hold_o), 64'd0);
      step();
      op_valid_i = 1'b0; flush_i = 1'b0;
      check("flush_idle.wb_en", 64'(wb_en_o), 64'd0);
      check("flush_idle.start", 64'(div_start_o), 64'd0);

      // Flush mid-BUSY followed by a late ready
      op_valid_i = 1'b1; op_i = 2'b00; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd3;
      step();
      op_valid_i = 1'b0;
      step(); step();
      check("flush_busy.start_before", 64'(div_start_o), 64'd1);
      flush_i = 1'b1;
      #1;
      check("flush_busy.hold", 64'(hold_o), 64'd0);
      step();
      flush_i = 1'b0; div_ready_i = 1'b1; div_result_i = {32'd2, 32'd14};
      #1;
      check("flush_busy.start_after", 64'(div_start_o), 64'd0);
      check("flush_busy.late_hold", 64'(hold_o), 64'd0);
      step();
      div_ready_i = 1'b0;
      check("flush_busy.no_wb", 64'(wb_en_o), 64'd0);
      step();
      check("flush_busy.no_wb2", 64'(wb_en_o), 64'd0);
      do_op("after_flush", 2'b01, 32'd100, 32'd7, 5'd3, 2, {32'd2, 32'd14}, 32'd14, 1'b0);

      // Divider never answers: timeout on the 40th BUSY cycle
      op_valid_i = 1'b1; op_i = 2'b01; dividend_i = 32'd9; divisor_i = 32'd2; rd_addr_i = 5'd4;
      step();
      op_valid_i = 1'b0;
      for (int k = 1; k < 40; k++) begin
         if (div_start_o !== 1'b1 || timeout_o !== 1'b0) check("timeout.wait", {div_start_o, timeout_o}, 64'd2);
         step();
      end
      check("timeout.wait_end", {div_start_o, timeout_o}, 64'd2);
      step();
      check("timeout.pulse", 64'(timeout_o), 64'd1);
      check("timeout.wb_en", 64'(wb_en_o), 64'd1);
      check("timeout.wb_data", 64'(wb_data_o), 64'd0);
      check("timeout.start", 64'(div_start_o), 64'd0);
      step();
      check("timeout.pulse_end", 64'(timeout_o), 64'd0);

      // Reset during a second BUSY
      op_valid_i = 1'b1; op_i = 2'b00; dividend_i = 32'd50; divisor_i = 32'd5; rd_addr_i = 5'd8;
      step();
      op_valid_i = 1'b0;
      step(); step();
      check("rst_busy.start_before", 64'(div_start_o), 64'd1);
      rst = 1'b1;
      step();
      check_idle_outputs("rst_busy");
      check("rst_busy.dividend_o", 64'(div_dividend_o), 64'd0);
      check("rst_busy.wb_data", 64'(wb_data_o), 64'd0);
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
      $finish;
   end

endmodule
